ram_access_ctrl: RTL and testbench

//  Initiator side of the gnrl-style single-port SRAM interface (cs/we/wem/addr/din/dout, combinational read).

---
 rtl/ram_access_ctrl_pkg.sv | 21 ++
 rtl/ram_data_align.sv | 53 +++++
 rtl/ram_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared size encodings, FSM states and alignment helper for the RAM access controller.
package ram_access_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    // An access is misaligned when its bytes straddle a word boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/ram_data_align.sv
// Combinational lane steering: store mask/data for both words of an access, load select + extension.
module ram_data_align
    import ram_access_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    output logic [3:0]  wem0_o,
    output logic [3:0]  wem1_o,
    output logic [31:0] din0_o,
    output logic [31:0] din1_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  mask;
    logic [63:0] din_sh;
    logic [63:0] merged;
    logic [31:0] ld_sel;
    logic [2:0]  bidx;

    always_comb begin
        case (size_i)
            SZ_B:    mask = 8'b0000_0001;
            SZ_H:    mask = 8'b0000_0011;
            default: mask = 8'b0000_1111;
        endcase
        mask   = mask << off_i;
        din_sh = {32'b0, wdata_i} << {off_i, 3'b000};
        wem0_o = mask[3:0];
        wem1_o = mask[7:4];
        din0_o = din_sh[31:0];
        din1_o = din_sh[63:32];

        // Load bytes are picked from the two-word window starting at the byte offset.
        merged = {word1_i, word0_i};
        ld_sel = 32'b0;
        bidx   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            bidx = {1'b0, off_i} + 3'(i);
            ld_sel[i*8 +: 8] = merged[{bidx, 3'b000} +: 8];
        end

        case (size_i)
            SZ_B:    rdata_o = {{24{~unsigned_i & ld_sel[7]}}, ld_sel[7:0]};
            SZ_H:    rdata_o = {{16{~unsigned_i & ld_sel[15]}}, ld_sel[15:0]};
            default: rdata_o = ld_sel;
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// LSU-to-SRAM access controller: one request in flight, registered RAM cycles, response held until accepted.
// MISALIGN_SPLIT_EN: split word-straddling accesses into two RAM cycles instead of erroring them.
module ram_access_ctrl #(
    parameter int AW     = 32,
    parameter int RAM_AW = 32,
    parameter int RAM_DP = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [3:0]        ram_wem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);
    import ram_access_ctrl_pkg::*;

    state_e              state_q;
    logic                req_ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0]         rsp_rdata_q;
    logic                ram_cs_q, ram_we_q;
    logic [3:0]          ram_wem_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [31:0]         ram_din_q;
    logic                we_q, uns_q, split_q;
    logic [1:0]          size_q, off_q;
    logic [31:0]         wdata_q, lo_q;
    logic [AW-1:0]       widx_q;

    logic                idle;
    logic [1:0]          cur_size, cur_off;
    logic [31:0]         cur_wdata, ld_w0, ld_data;
    logic [3:0]          wem_lo, wem_hi;
    logic [31:0]         din_lo, din_hi;
    logic [AW-1:0]       widx_d;
    logic                misal, oob, split_d, err_d;

    assign idle      = (state_q == ST_IDLE);
    // Store lanes for the first word are needed at accept time, so decode straight from the request.
    assign cur_size  = idle ? req_size        : size_q;
    assign cur_off   = idle ? req_addr[1:0]   : off_q;
    assign cur_wdata = idle ? req_wdata       : wdata_q;
    assign ld_w0     = (state_q == ST_ACC1) ? lo_q : ram_dout;

    assign widx_d = {2'b00, req_addr[AW-1:2]};
    assign misal  = is_misaligned(req_size, req_addr[1:0]);
    assign oob    = widx_d >= AW'(RAM_DP);

`ifdef MISALIGN_SPLIT_EN
    logic [AW-1:0] widx_nx;
    assign widx_nx = widx_d + AW'(1);
    assign split_d = misal;
    assign err_d   = (req_size == SZ_X) || oob || (misal && (widx_nx >= AW'(RAM_DP)));
`else
    assign split_d = 1'b0;
    assign err_d   = (req_size == SZ_X) || oob || misal;
`endif

    ram_data_align u_align (
        .size_i     (cur_size),
        .off_i      (cur_off),
        .unsigned_i (uns_q),
        .wdata_i    (cur_wdata),
        .word0_i    (ld_w0),
        .word1_i    (ram_dout),
        .wem0_o     (wem_lo),
        .wem1_o     (wem_hi),
        .din0_o     (din_lo),
        .din1_o     (din_hi),
        .rdata_o    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wem_q   <= 4'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 32'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            size_q      <= 2'b0;
            off_q       <= 2'b0;
            wdata_q     <= 32'b0;
            lo_q        <= 32'b0;
            widx_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    we_q        <= req_we;
                    size_q      <= req_size;
                    off_q       <= req_addr[1:0];
                    uns_q       <= req_unsigned;
                    wdata_q     <= req_wdata;
                    widx_q      <= widx_d;
                    split_q     <= split_d;
                    req_ready_q <= 1'b0;
                    if (err_d) begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'b0;
                    end else begin
                        state_q    <= ST_ACC0;
                        ram_cs_q   <= 1'b1;
                        ram_we_q   <= req_we;
                        ram_wem_q  <= req_we ? wem_lo : 4'b0;
                        ram_addr_q <= RAM_AW'(widx_d);
                        ram_din_q  <= req_we ? din_lo : 32'b0;
                    end
                end
                ST_ACC0, ST_ACC1: begin
                    if ((state_q == ST_ACC0) && split_q) begin
                        state_q    <= ST_ACC1;
                        lo_q       <= ram_dout;
                        ram_addr_q <= RAM_AW'(widx_q + AW'(1));
                        ram_wem_q  <= we_q ? wem_hi : 4'b0;
                        ram_din_q  <= we_q ? din_hi : 32'b0;
                    end else begin
                        state_q     <= ST_RSP;
                        ram_cs_q    <= 1'b0;
                        ram_we_q    <= 1'b0;
                        ram_wem_q   <= 4'b0;
                        ram_din_q   <= 32'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'b0 : ld_data;
                    end
                end
                ST_RSP: if (rsp_ready) begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_wem   = ram_wem_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: directed requests against a behavioural SRAM, RAM cycles and responses checked by monitors.
module tb_ram_access_ctrl;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, rsp_valid, rsp_err, ram_cs, ram_we;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata, ram_addr, ram_din, ram_dout;
    logic [3:0]  ram_wem;

    ram_access_ctrl #(.AW(32), .RAM_AW(32), .RAM_DP(512)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [512];
    initial for (int i = 0; i < 512; i++) mem[i] = 32'b0;
    assign ram_dout = (ram_addr < 32'd512) ? mem[ram_addr[8:0]] : 32'b0;
    always @(posedge clk)
        if (ram_cs && ram_we && ram_addr < 32'd512)
            for (int b = 0; b < 4; b++)
                if (ram_wem[b]) mem[ram_addr[8:0]][b*8 +: 8] <= ram_din[b*8 +: 8];

    typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
    typedef struct { logic we; logic [3:0] wem; logic [31:0] addr; logic [31:0] din; int lat; } ram_t;
    rsp_t rsp_q[$];
    ram_t ram_q[$];

    int cyc = 0, last_acc = 0, stall_cnt = 0;
    int n_cmp = 0, n_fail = 0;
    bit first_v = 1'b1;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rsp_valid && stall_cnt > 0) begin
            rsp_ready = 1'b0;
            stall_cnt--;
        end else rsp_ready = 1'b1;
    end

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
                e = rsp_q[0];
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                if (first_v) chk("rsp_latency", 32'(cyc - last_acc), 32'(e.lat));
                if (rsp_ready) begin
                    void'(rsp_q.pop_front());
                    first_v = 1'b1;
                end else first_v = 1'b0;
            end
        end
    end

    // RAM cycle monitor
    always @(negedge clk) begin
        ram_t r;
        logic [31:0] lm;
        if (ram_cs) begin
            if (ram_q.size() == 0) chk("ram_unexpected_cs", 32'(ram_cs), 32'd0);
            else begin
                r  = ram_q.pop_front();
                lm = {{8{r.wem[3]}}, {8{r.wem[2]}}, {8{r.wem[1]}}, {8{r.wem[0]}}};
                chk("ram_we", 32'(ram_we), 32'(r.we));
                chk("ram_addr", ram_addr, r.addr);
                chk("ram_wem", 32'(ram_wem), 32'(r.wem));
                if (r.we) chk("ram_din", ram_din & lm, r.din & lm);
                chk("ram_latency", 32'(cyc - last_acc), 32'(r.lat));
            end
        end
    end

    task automatic exp_ram(input logic we, input logic [3:0] wem, input logic [31:0] addr,
                           input logic [31:0] din, input int lat);
        ram_t r;
        r.we = we; r.wem = wem; r.addr = addr; r.din = din; r.lat = lat;
        ram_q.push_back(r);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd, input bit push, input logic [31:0] rd, input logic er,
                         input int lat);
        rsp_t e;
        int   n;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        last_acc = cyc;
        if (push) begin
            e.rdata = rd; e.err = er; e.lat = lat;
            rsp_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
        issue(we, addr, sz, uns, wd, 1'b1, rd, er, lat);
        for (int i = 0; i < 50 && rsp_q.size() != 0; i++) @(negedge clk);
        if (rsp_q.size() != 0) begin
            chk("rsp_timeout", 32'(rsp_q.size()), 32'd0);
            rsp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_wem"}, 32'(ram_wem), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_din"}, ram_din, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // word store, then byte/half loads of it
        exp_ram(1, 4'b1111, 4, 32'hDEADBEEF, 1);
        do_req(1, 32'h10, W, 0, 32'hDEADBEEF, 32'h0, 0, 2);
        exp_ram(0, 4'b0000, 4, 32'h0, 1);
        do_req(0, 32'h13, B, 0, 32'h0, 32'hFFFFFFDE, 0, 2);
        exp_ram(0, 4'b0000, 4, 32'h0, 1);
        do_req(0, 32'h13, B, 1, 32'h0, 32'h000000DE, 0, 2);
        exp_ram(0, 4'b0000, 4, 32'h0, 1);
        do_req(0, 32'h12, H, 0, 32'h0, 32'hFFFFDEAD, 0, 2);

        // half and byte stores into upper/middle lanes
        exp_ram(1, 4'b1100, 5, 32'h12340000, 1);
        do_req(1, 32'h16, H, 0, 32'h00001234, 32'h0, 0, 2);
        exp_ram(0, 4'b0000, 5, 32'h0, 1);
        do_req(0, 32'h16, H, 1, 32'h0, 32'h00001234, 0, 2);
        exp_ram(1, 4'b0010, 8, 32'h0000A500, 1);
        do_req(1, 32'h21, B, 0, 32'h000000A5, 32'h0, 0, 2);
        exp_ram(0, 4'b0000, 8, 32'h0, 1);
        do_req(0, 32'h20, W, 0, 32'h0, 32'h0000A500, 0, 2);

        // misaligned accesses across word boundaries
        exp_ram(1, 4'b1111, 3, 32'h11223344, 1);
        do_req(1, 32'h0C, W, 0, 32'h11223344, 32'h0, 0, 2);
`ifdef MISALIGN_SPLIT_EN
        exp_ram(0, 4'b0000, 3, 32'h0, 1);
        exp_ram(0, 4'b0000, 4, 32'h0, 2);
        do_req(0, 32'h0E, W, 0, 32'h0, 32'hBEEF1122, 0, 3);
        exp_ram(1, 4'b1000, 7, 32'hFE000000, 1);
        exp_ram(1, 4'b0001, 8, 32'h000000CA, 2);
        do_req(1, 32'h1F, H, 0, 32'h0000CAFE, 32'h0, 0, 3);
        exp_ram(0, 4'b0000, 7, 32'h0, 1);
        exp_ram(0, 4'b0000, 8, 32'h0, 2);
        do_req(0, 32'h1F, H, 1, 32'h0, 32'h0000CAFE, 0, 3);
        exp_ram(0, 4'b0000, 8, 32'h0, 1);
        do_req(0, 32'h20, W, 0, 32'h0, 32'h0000A5CA, 0, 2);
`else
        do_req(0, 32'h0E, W, 0, 32'h0, 32'h0, 1, 1);
        do_req(1, 32'h1F, H, 0, 32'h0000CAFE, 32'h0, 1, 1);
        do_req(0, 32'h1F, H, 1, 32'h0, 32'h0, 1, 1);
        exp_ram(0, 4'b0000, 8, 32'h0, 1);
        do_req(0, 32'h20, W, 0, 32'h0, 32'h0000A500, 0, 2);
`endif

        // illegal size and range boundaries
        do_req(0, 32'h0, X, 0, 32'h0, 32'h0, 1, 1);
        do_req(0, 32'h800, W, 0, 32'h0, 32'h0, 1, 1);
        do_req(1, 32'h800, B, 0, 32'hFF, 32'h0, 1, 1);
        exp_ram(0, 4'b0000, 511, 32'h0, 1);
        do_req(0, 32'h7FC, W, 0, 32'h0, 32'h0, 0, 2);
        do_req(0, 32'h7FE, W, 0, 32'h0, 32'h0, 1, 1);

        // response stalled for five cycles
        stall_cnt = 5;
        exp_ram(0, 4'b0000, 4, 32'h0, 1);
        do_req(0, 32'h10, W, 0, 32'h0, 32'hDEADBEEF, 0, 2);

        // reset during ACC0: no response, write already issued stays in RAM
        exp_ram(1, 4'b1111, 16, 32'h55555555, 1);
        issue(1, 32'h40, W, 0, 32'h55555555, 1'b0, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midop_reset");
        rst = 1'b0;
        exp_ram(0, 4'b0000, 16, 32'h0, 1);
        do_req(0, 32'h40, W, 0, 32'h0, 32'h55555555, 0, 2);

        repeat (3) @(negedge clk);
        chk("ram_q_drained", 32'(ram_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
